// File: rtl/cmult_seq.sv
// Sequential signed complex multiplier: one shared WIDTHxWIDTH multiplier reused
// over four cycles, then scaled by FRAC_BITS, saturated and registered.
module cmult_seq #(
  parameter int WIDTH     = 8,
  parameter int FRAC_BITS = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] re_a,
  input  logic [WIDTH-1:0] im_a,
  input  logic [WIDTH-1:0] re_q,
  input  logic [WIDTH-1:0] im_q,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] re_res,
  output logic [WIDTH-1:0] im_res
);

  localparam int ACC_W = 2*WIDTH + 1;
  localparam int PRD_W = 2*WIDTH;

  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((64'sd1 <<< (WIDTH-1)) - 64'sd1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-(64'sd1 <<< (WIDTH-1)));

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    P_AC   = 3'd1,
    P_BD   = 3'd2,
    P_AD   = 3'd3,
    P_BC   = 3'd4,
    FINISH = 3'd5
  } state_t;

  state_t r_state, w_next;

  logic signed [WIDTH-1:0] r_re_a, r_im_a, r_re_q, r_im_q;
  logic signed [ACC_W-1:0] r_re_acc, r_im_acc;
  logic                    r_busy, r_done;
  logic        [WIDTH-1:0] r_re_res, r_im_res;

  logic signed [WIDTH-1:0] w_mul_x, w_mul_y;
  logic signed [PRD_W-1:0] w_prod;
  logic signed [ACC_W-1:0] w_prod_ext;
  logic signed [ACC_W-1:0] w_re_shift, w_im_shift;
  logic        [WIDTH-1:0] w_re_sat, w_im_sat;

  function automatic logic [WIDTH-1:0] sat(input logic signed [ACC_W-1:0] v);
    if (v > SAT_MAX)      sat = SAT_MAX[WIDTH-1:0];
    else if (v < SAT_MIN) sat = SAT_MIN[WIDTH-1:0];
    else                  sat = v[WIDTH-1:0];
  endfunction

  // Operand steering for the single shared multiplier, one partial product per state.
  always_comb begin
    w_mul_x = '0;
    w_mul_y = '0;
    case (r_state)
      P_AC:    begin w_mul_x = r_re_q; w_mul_y = r_re_a; end
      P_BD:    begin w_mul_x = r_im_q; w_mul_y = r_im_a; end
      P_AD:    begin w_mul_x = r_re_q; w_mul_y = r_im_a; end
      P_BC:    begin w_mul_x = r_im_q; w_mul_y = r_re_a; end
      default: begin w_mul_x = '0;     w_mul_y = '0;     end
    endcase
  end

  assign w_prod     = w_mul_x * w_mul_y;
  assign w_prod_ext = {w_prod[PRD_W-1], w_prod};

  // Arithmetic shift truncates toward -inf before the clamp.
  assign w_re_shift = r_re_acc >>> FRAC_BITS;
  assign w_im_shift = r_im_acc >>> FRAC_BITS;
  assign w_re_sat   = sat(w_re_shift);
  assign w_im_sat   = sat(w_im_shift);

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = P_AC;
      P_AC:    w_next = P_BD;
      P_BD:    w_next = P_AD;
      P_AD:    w_next = P_BC;
      P_BC:    w_next = FINISH;
      FINISH:  w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= IDLE;
      r_re_a   <= '0;
      r_im_a   <= '0;
      r_re_q   <= '0;
      r_im_q   <= '0;
      r_re_acc <= '0;
      r_im_acc <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_re_res <= '0;
      r_im_res <= '0;
    end else begin
      r_state <= w_next;
      // busy/done are flopped from next-state so outputs never see start combinationally.
      r_busy  <= (w_next != IDLE);
      r_done  <= (r_state == FINISH);
      case (r_state)
        IDLE: if (start) begin
          r_re_a <= re_a;
          r_im_a <= im_a;
          r_re_q <= re_q;
          r_im_q <= im_q;
        end
        P_AC:   r_re_acc <= w_prod_ext;
        P_BD:   r_re_acc <= r_re_acc - w_prod_ext;
        P_AD:   r_im_acc <= w_prod_ext;
        P_BC:   r_im_acc <= r_im_acc + w_prod_ext;
        FINISH: begin
          r_re_res <= w_re_sat;
          r_im_res <= w_im_sat;
        end
        default: ;
      endcase
    end
  end

  assign busy   = r_busy;
  assign done   = r_done;
  assign re_res = r_re_res;
  assign im_res = r_im_res;

endmodule

// File: tb/tb_cmult_seq.sv
// Directed bench for cmult_seq: an unscaled instance and a FRAC_BITS=6 instance.
module tb_cmult_seq;

  logic clk = 1'b0;
  logic reset = 1'b1;

  logic              start0 = 1'b0, start6 = 1'b0;
  logic signed [7:0] re_a0 = '0, im_a0 = '0, re_q0 = '0, im_q0 = '0;
  logic signed [7:0] re_a6 = '0, im_a6 = '0, re_q6 = '0, im_q6 = '0;
  logic              busy0, done0, busy6, done6;
  logic        [7:0] re_res0, im_res0, re_res6, im_res6;

  int nchk = 0;
  int nfail = 0;

  always #5 clk = ~clk;

  cmult_seq #(.WIDTH(8), .FRAC_BITS(0)) u0 (
    .clk(clk), .reset(reset), .start(start0),
    .re_a(re_a0), .im_a(im_a0), .re_q(re_q0), .im_q(im_q0),
    .busy(busy0), .done(done0), .re_res(re_res0), .im_res(im_res0)
  );

  cmult_seq #(.WIDTH(8), .FRAC_BITS(6)) u6 (
    .clk(clk), .reset(reset), .start(start6),
    .re_a(re_a6), .im_a(im_a6), .re_q(re_q6), .im_q(im_q6),
    .busy(busy6), .done(done6), .re_res(re_res6), .im_res(im_res6)
  );

  task automatic check(input string name, input logic signed [31:0] got, input logic signed [31:0] exp);
    nchk++;
    assert (got === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0d expected %0d", name, got, exp);
    end
  endtask

  // One operation: start is high for exactly the accepting edge, then the result is awaited.
  task automatic op(input bit sel, input int rq, input int iq, input int ra, input int ia,
                    output logic signed [7:0] ore, output logic signed [7:0] oim,
                    output int nbusy, output bit got);
    ore = 'x; oim = 'x; nbusy = 0; got = 1'b0;
    @(negedge clk);
    if (sel) begin
      re_q6 = 8'(rq); im_q6 = 8'(iq); re_a6 = 8'(ra); im_a6 = 8'(ia); start6 = 1'b1;
    end else begin
      re_q0 = 8'(rq); im_q0 = 8'(iq); re_a0 = 8'(ra); im_a0 = 8'(ia); start0 = 1'b1;
    end
    @(posedge clk);
    #1 start0 = 1'b0; start6 = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      if (sel ? done6 : done0) begin
        got = 1'b1;
        ore = sel ? re_res6 : re_res0;
        oim = sel ? im_res6 : im_res0;
      end else if (sel ? busy6 : busy0) begin
        nbusy++;
      end
    end
  endtask

  logic signed [7:0] r_re, r_im;
  int nb, ndone, first_k, last_k, gap;
  bit got;

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    check("rst_busy", busy0, 0);
    check("rst_done", done0, 0);
    check("rst_re", $signed(re_res0), 0);
    check("rst_im", $signed(im_res0), 0);
    reset = 1'b0;

    // Basic: (3+4j)(1+2j) = -5+10j
    op(0, 3, 4, 1, 2, r_re, r_im, nb, got);
    check("basic_got", got, 1);
    check("basic_re", r_re, -5);
    check("basic_im", r_im, 10);
    check("basic_busy_cycles", nb, 5);
    check("basic_busy_in_done", busy0, 0);
    @(negedge clk);
    check("basic_done_drops", done0, 0);
    check("basic_hold_re", $signed(re_res0), -5);

    // Mixed signs, no saturation: (-7+5j)(9-3j) = -48+66j
    op(0, -7, 5, 9, -3, r_re, r_im, nb, got);
    check("mixed_re", r_re, -48);
    check("mixed_im", r_im, 66);

    // Positive saturation
    op(0, -128, 0, -128, 0, r_re, r_im, nb, got);
    check("psat1_re", r_re, 127);
    check("psat1_im", r_im, 0);
    op(0, 127, 127, 127, -127, r_re, r_im, nb, got);
    check("psat2_re", r_re, 127);
    check("psat2_im", r_im, 0);

    // Negative saturation
    op(0, -128, 0, 127, 0, r_re, r_im, nb, got);
    check("nsat1_re", r_re, -128);
    check("nsat1_im", r_im, 0);
    op(0, 0, 127, 0, 127, r_re, r_im, nb, got);
    check("nsat2_re", r_re, -128);
    check("nsat2_im", r_im, 0);

    // FRAC_BITS=6 scaling
    op(1, 64, 0, 64, 0, r_re, r_im, nb, got);
    check("frac_got", got, 1);
    check("frac_re", r_re, 64);
    check("frac_im", r_im, 0);
    op(1, -1, 0, 1, 0, r_re, r_im, nb, got);
    check("frac_trunc_re", r_re, -1);
    check("frac_trunc_im", r_im, 0);

    // Start pulses while busy and operand changes after acceptance are ignored
    @(negedge clk);
    re_q0 = 8'sd3; im_q0 = 8'sd4; re_a0 = 8'sd1; im_a0 = 8'sd2; start0 = 1'b1;
    @(posedge clk);
    #1 start0 = 1'b0;
    re_q0 = 8'sd100; im_q0 = 8'sd100; re_a0 = 8'sd100; im_a0 = 8'sd100;
    ndone = 0; r_re = 'x; r_im = 'x;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (done0) begin ndone++; r_re = re_res0; r_im = im_res0; end
      start0 = (k >= 2 && k <= 4);
    end
    check("ignore_ndone", ndone, 1);
    check("ignore_re", r_re, -5);
    check("ignore_im", r_im, 10);

    // Start held high: one completion every 6 cycles; (2+1j)(3+0j) = 6+3j
    @(negedge clk);
    re_q0 = 8'sd2; im_q0 = 8'sd1; re_a0 = 8'sd3; im_a0 = 8'sd0; start0 = 1'b1;
    ndone = 0; first_k = -1; last_k = -1; gap = -1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (done0) begin
        ndone++;
        if (first_k < 0) first_k = k; else gap = k - last_k;
        last_k = k;
        r_re = re_res0; r_im = im_res0;
      end
    end
    start0 = 1'b0;
    check("b2b_ndone", ndone, 3);
    check("b2b_first", first_k, 6);
    check("b2b_gap", gap, 6);
    check("b2b_re", r_re, 6);
    check("b2b_im", r_im, 3);
    repeat (8) @(negedge clk);
    check("b2b_idle", busy0, 0);

    // Reset during P_BD aborts the operation
    @(negedge clk);
    re_q0 = 8'sd5; im_q0 = 8'sd6; re_a0 = 8'sd7; im_a0 = 8'sd8; start0 = 1'b1;
    @(posedge clk);
    #1 start0 = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
    check("abort_busy", busy0, 0);
    check("abort_done", done0, 0);
    check("abort_re", $signed(re_res0), 0);
    check("abort_im", $signed(im_res0), 0);
    @(negedge clk);
    reset = 1'b0;
    ndone = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (done0) ndone++;
    end
    check("abort_no_done", ndone, 0);
    check("abort_idle", busy0, 0);
    check("abort_re_held", $signed(re_res0), 0);

    // Recovery: (5+6j)(7+8j) = -13+82j
    op(0, 5, 6, 7, 8, r_re, r_im, nb, got);
    check("recover_got", got, 1);
    check("recover_re", r_re, -13);
    check("recover_im", r_im, 82);
    check("recover_busy_cycles", nb, 5);

    $display("%0d/%0d checks passed", nchk - nfail, nchk);
    $finish;
  end

endmodule
